// File: rtl/axi4_stream_gen.sv
// rtl/axi4_stream_gen.sv - AXI4-Stream counting-pattern packet generator
// Packets of cfg_len beats carry a free-running lane counter, separated by cfg_gap idle cycles.
module axi4_stream_gen #(
  parameter int DN = 1,
  parameter int DW = 8
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               ctl_str,
  input  logic               ctl_stp,
  input  logic [15:0]        cfg_len,
  input  logic [15:0]        cfg_num,
  input  logic [7:0]         cfg_gap,
  input  logic [DN-1:0]      cfg_kep,
  output logic               sts_bsy,
  output logic [15:0]        sts_pkt,
  output logic [DN*DW-1:0]   TDATA,
  output logic [DN-1:0]      TKEEP,
  output logic               TLAST,
  output logic               TVALID,
  input  logic               TREADY
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        state_q;
  logic [15:0]   len_q;
  logic [15:0]   num_q;
  logic [7:0]    gap_q;
  logic [DN-1:0] kep_q;
  logic [15:0]   pkt_q;
  logic [15:0]   beat_q;
  logic [15:0]   bip_q;
  logic [7:0]    gcnt_q;
  logic          stop_q;

  logic          xfer;
  logic          is_last;
  logic          num_hit;
  logic          stop_now;
  logic [15:0]   pkt_d;
  logic [15:0]   beat_d;
  logic [15:0]   bip_d;

  always_comb begin
    xfer     = (state_q == S_SEND) && TREADY;
    is_last  = (bip_q == len_q - 16'd1);
    pkt_d    = (pkt_q == 16'hFFFF) ? pkt_q : pkt_q + 16'd1;
    num_hit  = (num_q != 16'd0) && (({1'b0, pkt_q} + 17'd1) == {1'b0, num_q});
    stop_now = stop_q | ctl_stp;
    beat_d   = beat_q + 16'd1;
    bip_d    = bip_q + 16'd1;
  end

  // Outputs decode registered state only, so nothing here looks at TREADY.
  assign TVALID  = (state_q == S_SEND);
  assign TLAST   = TVALID & is_last;
  assign TKEEP   = TVALID ? (is_last ? kep_q : {DN{1'b1}}) : {DN{1'b0}};
  assign sts_bsy = (state_q != S_IDLE);
  assign sts_pkt = pkt_q;

  always_comb begin
    logic [DW-1:0] lane;
    TDATA = '0;
    lane  = '0;
    for (int i = 0; i < DN; i++) begin
      lane = DW'(32'(beat_q) * 32'(DN) + 32'(i));
      if (TVALID) TDATA[i*DW +: DW] = lane;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      kep_q   <= '0;
      pkt_q   <= '0;
      beat_q  <= '0;
      bip_q   <= '0;
      gcnt_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctl_str) begin
            state_q <= S_SEND;
            len_q   <= (cfg_len == 16'd0) ? 16'd1 : cfg_len;
            num_q   <= cfg_num;
            gap_q   <= cfg_gap;
            kep_q   <= cfg_kep;
            pkt_q   <= '0;
            beat_q  <= '0;
            bip_q   <= '0;
            stop_q  <= ctl_stp;
          end
        end
        S_SEND: begin
          if (ctl_stp) stop_q <= 1'b1;
          if (xfer) begin
            beat_q <= beat_d;
            if (is_last) begin
              bip_q <= '0;
              pkt_q <= pkt_d;
              if (num_hit || stop_now) begin
                state_q <= S_IDLE;
                stop_q  <= 1'b0;
              end else if (gap_q != 8'd0) begin
                state_q <= S_GAP;
                gcnt_q  <= gap_q;
              end
            end else begin
              bip_q <= bip_d;
            end
          end
        end
        S_GAP: begin
          // A pending stop ends the run here since no packet is in flight.
          if (stop_now) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
          end else if (gcnt_q == 8'd1) begin
            state_q <= S_SEND;
          end else begin
            gcnt_q <= gcnt_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_stream_gen.md
AXI4_STREAM_GEN -- requirements
Module: axi4_stream_gen

Interface
REQ-001 SHALL have parameter DN, default 1: number of data lanes per beat.
REQ-002 SHALL have parameter DW, default 8: bits per lane.
REQ-003 SHALL have port ACLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ctl_str  input  1  start pulse.
REQ-006 SHALL have port ctl_stp  input  1  stop request.
REQ-007 SHALL have port cfg_len  input  16  beats per packet; 0 is treated as 1.
REQ-008 SHALL have port cfg_num  input  16  packets per run; 0 means run until stopped.
REQ-009 SHALL have port cfg_gap  input  8  idle cycles between packets.
REQ-010 SHALL have port cfg_kep  input  DN  TKEEP value for the last beat.
REQ-011 SHALL have port sts_bsy  output  1  high while a run is active.
REQ-012 SHALL have port sts_pkt  output  16  packets completed in the current or last run.
REQ-013 SHALL have port TDATA  output  DN*DW  stream data.
REQ-014 SHALL have port TKEEP  output  DN  lane enables.
REQ-015 SHALL have port TLAST  output  1  last beat of a packet.
REQ-016 SHALL have port TVALID  output  1  beat valid.
REQ-017 SHALL have port TREADY  input  1  sink ready.

Function
REQ-018 SHALL implement the FSM states IDLE, SEND and GAP; sts_bsy = (state != IDLE).
REQ-019 In IDLE, ctl_str=1 SHALL latch cfg_len/num/gap/kep, clear sts_pkt and the beat counter, and enter SEND next cycle; TVALID SHALL rise on the cycle after ctl_str.
REQ-020 ctl_str while not IDLE SHALL be ignored; cfg_* changes SHALL have no effect until the next start.
REQ-021 A transfer SHALL occur on each edge where TVALID & TREADY; TVALID SHALL NOT depend combinationally on TREADY.
REQ-022 Once TVALID=1, TVALID, TDATA, TKEEP and TLAST SHALL hold stable until a transfer.
REQ-023 Data SHALL be a free-running beat counter b (reset to 0 at start, +1 per transfer, not reset between packets); lane i of TDATA = (b*DN + i) mod 2^DW.
REQ-024 TKEEP SHALL be all ones on non-last beats and the latched cfg_kep on the last beat; TLAST SHALL be 1 exactly on beat cfg_len-1 of each packet.
REQ-025 On the TLAST transfer, sts_pkt SHALL increment (saturating at 0xFFFF).
REQ-026 After the TLAST transfer: if cfg_num!=0 and sts_pkt+1==cfg_num, or a stop is pending, the FSM SHALL go to IDLE; otherwise it SHALL go to GAP if gap>0, else stay in SEND, with TVALID=1 on the next beat (back-to-back).
REQ-027 GAP SHALL hold TVALID=0 for exactly gap cycles, then return to SEND.
REQ-028 ctl_stp SHALL set a pending flag; a stop SHALL never truncate a packet; in GAP it SHALL cause an immediate return to IDLE; in IDLE it SHALL be ignored; the flag SHALL clear on entering IDLE.
REQ-029 ctl_str and ctl_stp in the same IDLE cycle SHALL start a run and set the stop flag, so exactly one packet is sent.
REQ-030 cfg_len=1 SHALL produce single-beat packets with TLAST=1 and TKEEP=cfg_kep on every beat.
REQ-031 The beat-in-packet counter SHALL be 16 bits, and b SHALL wrap modulo 2^16 without a glitch.

Reset
REQ-032 While ARESETn=0 at a rising edge: state=IDLE; TVALID=0, TLAST=0, TKEEP=0, TDATA=0; sts_bsy=0, sts_pkt=0; stop flag and counters cleared.
REQ-033 Reset mid-packet SHALL drop TVALID on the next edge with no TLAST emitted; no packet is resumed after reset.

Verification
REQ-034 DN=1, DW=8, len=4, num=2, gap=0, kep=1, TREADY=1 -> beats 0,1,2,3(LAST),4,5,6,7(LAST) on 8 consecutive cycles; sts_pkt=2, then IDLE.
REQ-035 len=3, num=2, gap=2 -> 3 beats, exactly 2 cycles of TVALID=0, 3 beats; sts_bsy falls after the 6th transfer.
REQ-036 Random TREADY back-pressure (50%) -> TVALID/TDATA stable while stalled; the received sequence is the unbroken count 0..N-1, TLAST every len beats.
REQ-037 num=0, len=5, ctl_stp pulsed at beat 2 of packet 3 -> packet 3 completes (5 beats, TLAST), then IDLE with sts_pkt=3.
REQ-038 DN=4, DW=8, len=2, kep=4'b0011 -> beat0 TDATA=0x03020100 with TKEEP=0xF; beat1 TDATA=0x07060504 with TKEEP=0x3 and TLAST=1.
REQ-039 ARESETn low for 1 cycle mid-packet -> TVALID=0 next edge, all outputs at reset values; a fresh start restarts the data at 0.
